// File: rtl/hasti_sram.sv
// ============================================================================
// hasti_sram : AHB-Lite slave in front of a single-port word-wide SRAM.
// Optional macro HASTI_SRAM_WAIT_EN adds one wait state to every legal transfer.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module hasti_sram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
`ifdef HASTI_SRAM_WAIT_EN
        ,
        S_WAIT = 2'd3
`endif
    } state_t;

    state_t                state;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [3:0]            pend_lanes;
`ifdef HASTI_SRAM_WAIT_EN
    logic                  rd_pend;
`endif

    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            lanes;
    logic                  illegal;
    logic                  accept;
    logic                  commit;
    logic                  unused_ok;

    assign idx       = haddr[ADDR_WIDTH+1:2];
    assign unused_ok = &{1'b0, hburst, hmastlock, hprot, htrans[0], haddr[31:ADDR_WIDTH+2]};

    // Our own hready gates acceptance so nothing is taken while we stall.
    assign accept  = hsel & hready_in & hready & htrans[1];
    assign commit  = wr_pend & hready;
    assign illegal = (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    always_comb begin
        lanes = 4'b0000;
        case (hsize)
            3'd0:    lanes = 4'b0001 << haddr[1:0];
            3'd1:    lanes = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
    end

`ifndef HASTI_SRAM_WAIT_EN
    logic [31:0] fwd_word;

    // A read accepted on the commit edge of a same-word write sees the new lanes.
    always_comb begin
        fwd_word = mem[idx];
        if (commit && (pend_addr == idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_lanes[b]) begin
                    fwd_word[8*b +: 8] = hwdata[8*b +: 8];
                end
            end
        end
    end
`endif

    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_lanes[b]) begin
                    mem[pend_addr][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= S_IDLE;
            hready     <= 1'b1;
            hresp      <= 1'b0;
            hrdata     <= 32'h0000_0000;
            wr_pend    <= 1'b0;
            pend_addr  <= '0;
            pend_lanes <= 4'b0000;
`ifdef HASTI_SRAM_WAIT_EN
            rd_pend    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                wr_pend    <= ~illegal & hwrite;
                pend_addr  <= idx;
                pend_lanes <= lanes;
            end else if (commit) begin
                wr_pend    <= 1'b0;
            end

            case (state)
                S_ERR1: begin
                    state  <= S_ERR2;
                    hready <= 1'b1;
                    hresp  <= 1'b1;
                end
`ifdef HASTI_SRAM_WAIT_EN
                S_WAIT: begin
                    state   <= S_IDLE;
                    hready  <= 1'b1;
                    hresp   <= 1'b0;
                    rd_pend <= 1'b0;
                    if (rd_pend) begin
                        hrdata <= mem[pend_addr];
                    end
                end
`endif
                default: begin
                    if (accept && illegal) begin
                        state  <= S_ERR1;
                        hready <= 1'b0;
                        hresp  <= 1'b1;
                    end else if (accept) begin
`ifdef HASTI_SRAM_WAIT_EN
                        state   <= S_WAIT;
                        hready  <= 1'b0;
                        hresp   <= 1'b0;
                        rd_pend <= ~hwrite;
`else
                        state  <= S_IDLE;
                        hready <= 1'b1;
                        hresp  <= 1'b0;
                        if (!hwrite) begin
                            hrdata <= fwd_word;
                        end
`endif
                    end else begin
                        state  <= S_IDLE;
                        hready <= 1'b1;
                        hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hasti_sram.sv
// ============================================================================
// tb_hasti_sram : table-driven and random AHB-Lite transfers against a
// transfer-level memory model. Honours HASTI_SRAM_WAIT_EN when defined.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_hasti_sram;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          has_exp;
        logic [31:0] exp;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready_in;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    assign hready_in = hready;

    hasti_sram #(.ADDR_WIDTH(12)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hmastlock (hmastlock),
        .hprot     (hprot),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 hclk = ~hclk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;
    bit          last_known;
    xfer_t       pend [$];
    xfer_t       tbl  [$];
    xfer_t       dp;
    bit          dp_valid;
    int          dp_cyc;

    function automatic xfer_t mk(bit sel, logic [1:0] tr, bit wr, logic [2:0] sz,
                                 logic [31:0] a, logic [31:0] d, bit he, logic [31:0] e);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.write = wr; x.size = sz;
        x.addr = a; x.wdata = d; x.has_exp = he; x.exp = e;
        return x;
    endfunction

    function automatic bit is_illegal(xfer_t x);
        return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
               (x.size == 3'd2 && x.addr[1:0] != 2'b00);
    endfunction

    function automatic void model_write(xfer_t x);
        int          wi = int'(x.addr[13:2]);
        int          n  = 1 << x.size;
        int          base = int'(x.addr[1:0]);
        logic [31:0] w;
        if (!ref_mem.exists(wi)) begin
            if (n == 4) ref_mem[wi] = x.wdata;
            return;
        end
        w = ref_mem[wi];
        for (int b = base; b < base + n; b++) w[8*b +: 8] = x.wdata[8*b +: 8];
        ref_mem[wi] = w;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit exp_rdy = 1'b1;
        bit exp_resp = 1'b0;
        bit data_chk = 1'b0;
        int wi;
        if (dp_valid) begin
            if (is_illegal(dp)) begin
                exp_rdy  = (dp_cyc != 0);
                exp_resp = 1'b1;
            end else begin
`ifdef HASTI_SRAM_WAIT_EN
                exp_rdy = (dp_cyc != 0);
`endif
                data_chk = !dp.write && exp_rdy;
            end
        end
        chk("hready", {31'b0, hready}, {31'b0, exp_rdy});
        chk("hresp", {31'b0, hresp}, {31'b0, exp_resp});
        if (data_chk) begin
            wi = int'(dp.addr[13:2]);
            if (ref_mem.exists(wi)) begin
                chk("hrdata_model", hrdata, ref_mem[wi]);
                last_rd    = ref_mem[wi];
                last_known = 1'b1;
            end else begin
                last_known = 1'b0;
            end
            if (dp.has_exp) chk("hrdata_table", hrdata, dp.exp);
        end else if (last_known) begin
            chk("hrdata_hold", hrdata, last_rd);
        end
    endtask

    // Drives queued transfers as a pipelined master; returns one cycle after the last data phase.
    task automatic run();
        xfer_t idle_x = mk(0, 2'b00, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
        xfer_t a;
        int    budget = 4 * pend.size() + 10;
        bit    rdy;
        while (pend.size() > 0 || dp_valid) begin
            a = (pend.size() > 0) ? pend[0] : idle_x;
            hsel   = a.sel;
            htrans = a.trans;
            hwrite = a.write;
            hsize  = a.size;
            haddr  = a.addr;
            hwdata = (dp_valid && dp.write) ? dp.wdata : $urandom();
            @(negedge hclk);
            check_cycle();
            rdy = hready;
            if (rdy) begin
                if (dp_valid && dp.write && !is_illegal(dp)) model_write(dp);
                dp_valid = 1'b0;
                if (pend.size() > 0) begin
                    a = pend.pop_front();
                    if (a.sel && a.trans[1]) begin
                        dp = a; dp_valid = 1'b1; dp_cyc = 0;
                    end
                end
            end else begin
                dp_cyc++;
            end
            @(posedge hclk); #1;
            budget--;
            if (budget <= 0) begin
                n_vec++; n_bad++;
                $display("FAIL timeout: got stalled bus, expected progress at %0t", $time);
                pend.delete();
                dp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
        hburst = 3'd0; hmastlock = 1'b0; hprot = 4'h0; htrans = 2'b00; hwdata = 32'h0;
        dp_valid = 1'b0; dp_cyc = 0; last_rd = 32'h0; last_known = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_hready", {31'b0, hready}, 32'h1);
        chk("reset_hresp", {31'b0, hresp}, 32'h0);
        chk("reset_hrdata", hrdata, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Directed table, issued back to back
        tbl.push_back(mk(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 2'b10, 1, 3'd2, 32'h20, 32'h11223344, 0, 0));
        tbl.push_back(mk(1, 2'b10, 1, 3'd0, 32'h21, 32'h0000AA00, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h20, 32'h0, 1, 32'h1122AA44));
        tbl.push_back(mk(1, 2'b10, 1, 3'd2, 32'h30, 32'h00000000, 0, 0));
        tbl.push_back(mk(1, 2'b10, 1, 3'd1, 32'h32, 32'hBEEF0000, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h30, 32'h0, 1, 32'hBEEF0000));
        tbl.push_back(mk(1, 2'b10, 1, 3'd2, 32'h40, 32'h01020304, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd1, 32'h41, 32'h0, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 1, 32'h01020304));
        tbl.push_back(mk(1, 2'b10, 1, 3'd3, 32'h40, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 2'b11, 1, 3'd2, 32'h42, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 2'b00, 1, 3'd2, 32'h10, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, 2'b10, 1, 3'd2, 32'h10, 32'h00000000, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 1, 32'h01020304));
        tbl.push_back(mk(1, 2'b10, 0, 3'd0, 32'h23, 32'h0, 1, 32'h1122AA44));
        tbl.push_back(mk(1, 2'b10, 1, 3'd0, 32'h23, 32'h5500_0000, 0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 3'd2, 32'h4020, 32'h0, 1, 32'h5522AA44));
        for (int i = 0; i < tbl.size(); i++) pend.push_back(tbl[i]);
        run();

        // Reset in the middle of a write data phase
        pend.push_back(mk(1, 2'b10, 1, 3'd2, 32'h50, 32'h5A5A0F0F, 0, 0));
        pend.push_back(mk(1, 2'b10, 0, 3'd2, 32'h50, 32'h0, 1, 32'h5A5A0F0F));
        run();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h50;
        @(negedge hclk);
        chk("wr_accept_hready", {31'b0, hready}, 32'h1);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        #2 hresetn = 1'b0;
        #1;
        chk("midreset_hready", {31'b0, hready}, 32'h1);
        chk("midreset_hresp", {31'b0, hresp}, 32'h0);
        chk("midreset_hrdata", hrdata, 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        last_rd = 32'h0; last_known = 1'b1;
        pend.push_back(mk(1, 2'b10, 0, 3'd2, 32'h50, 32'h0, 1, 32'h5A5A0F0F));
        run();

        // Randomised traffic over 16 words with aliased upper address bits
        for (int i = 0; i < 16; i++)
            pend.push_back(mk(1, 2'b10, 1, 3'd2, {18'($urandom()), 8'h00, 4'(i), 2'b00},
                              $urandom(), 0, 0));
        run();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            pend.push_back(mk(($urandom_range(0, 7) != 0), 2'($urandom()), 1'($urandom()), sz,
                              {18'($urandom()), 8'h00, 4'($urandom_range(0, 15)), 2'($urandom())},
                              $urandom(), 0, 0));
        end
        run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hasti_sram.md
# hasti_sram

AHB-Lite (HASTI) slave that terminates one crossbar slave port with a single-port, word-organised on-chip SRAM. Accepts pipelined address/data phases from the crossbar's slave mux and performs byte, halfword and word reads and writes. Returns a two-cycle ERROR response for illegal transfers. Forwards write data into an immediately following read of the same word.

## Interface
- ADDR_WIDTH, 12, word-address bits; capacity 2^ADDR_WIDTH words of 32 bits.
- hclk  input  1  clock; all state updates on rising edge.
- hresetn  input  1  reset, asynchronous, active-low.
- hsel  input  1  slave select from address decoder.
- haddr  input  32  byte address; bits [ADDR_WIDTH+1:2] index the word, higher bits ignored (aliasing).
- hwrite  input  1  1 = write.
- hsize  input  3  0 byte, 1 halfword, 2 word.
- hburst  input  3  ignored.
- hmastlock  input  1  ignored.
- hprot  input  4  ignored.
- htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwdata  input  32  write data, valid in data phase.
- hready_in  input  1  bus HREADY from slave mux.
- hrdata  output  32  read data.
- hready  output  1  HREADYOUT.
- hresp  output  1  0 OKAY, 1 ERROR.

## Operation
- Address phase accepted on an edge where hsel & hready_in & htrans[1]. IDLE/BUSY, or hsel=0: no action, next data phase OKAY zero-wait.
- Illegal transfer: hsize>2, or hsize=1 & haddr[0], or hsize=2 & haddr[1:0]!=0. An illegal transfer does not touch memory and gets an ERROR response.
- Byte lanes from haddr[1:0]/hsize. Size 0: lane haddr[1:0]. Size 1: lanes {2,3} if haddr[1], else {0,1}. Size 2: all lanes.
- Accepted write: address, lanes and write flag latched. On the edge completing the data phase, the mem word is updated only in the selected lanes with hwdata. Unselected lanes are unchanged.
- Accepted read: mem word read on the accept edge into the read register. hrdata is driven with the full word, all lanes, during the data phase.
- Forwarding: if a read is accepted on the same edge a pending write commits, and the word index matches, the written lanes of hrdata come from hwdata and the rest from mem.
- States: IDLE (no data phase or OKAY data phase), WAIT (macro only), ERR1, ERR2.
- IDLE → ERR1 on accepting an illegal transfer. ERR1 → ERR2 unconditionally. ERR2 → IDLE, or ERR1 if another illegal transfer is accepted.
- Address phases presented during ERR2 with hready_in=1 are accepted normally.
- Memory contents are not reset.

## Timing
- Reset values: hready=1, hresp=0, hrdata=0, state IDLE, no pending write.
- Reset asserted mid data phase: the pending write is discarded and outputs take their reset values immediately.
- Legal transfer, macro off: zero wait states. Read data is valid in the cycle after address acceptance. The write commits at the end of that cycle.
- ERROR response: ERR1 drives hready=0, hresp=1. ERR2 drives hready=1, hresp=1.
- hrdata holds its last value outside read data phases.
- Back-to-back transfers (write→read, read→write, write→write) sustain one transfer per cycle with no stall.

## Configuration
- HASTI_SRAM_WAIT_EN defined: every legal transfer inserts exactly one wait state.
  - The first data-phase cycle is in WAIT with hready=0 and hresp=0.
  - The second data-phase cycle has hready=1.
  - The read register is loaded on entry to the final data-phase cycle.
  - The write commits at the end of the final data-phase cycle.
  - Forwarding applies when the next read is accepted on that final edge.
  - Illegal transfers still use ERR1/ERR2 with no extra wait.
- HASTI_SRAM_WAIT_EN undefined: the WAIT state is absent and all legal transfers are zero-wait.

## Test plan
- Word write 0xDEADBEEF to 0x10, then read 0x10 → hrdata=0xDEADBEEF, hready=1 and hresp=0 every cycle.
- Word 0x11223344 at 0x20, then byte write 0xAA to 0x21 (hwdata 0x0000AA00), read 0x20 → 0x1122AA44.
- Halfword write 0xBEEF to 0x32 immediately followed by a read of 0x30 (back-to-back), old word 0x00000000 → hrdata=0xBEEF0000, no stall.
- Halfword read at 0x41 → one cycle hready=0/hresp=1, then hready=1/hresp=1. A following word read at 0x40 returns unchanged contents.
- htrans=IDLE with hsel=1 and htrans=NONSEQ with hsel=0 → hready=1, hresp=0, memory unchanged.
- With HASTI_SRAM_WAIT_EN: word read at 0x10 → exactly one hready=0 cycle, then data. With the macro off, the same read has zero wait states. Reset asserted during a write data phase → memory unchanged at that address, hready=1, hresp=0.
